// File: rtl/swg_window_gen.sv
// Streaming K x K sliding-window generator over a virtually padded, channel-folded raster frame.
// Line buffers hold the previous K-1 rows; per-row shift registers provide the horizontal taps.
module swg_window_gen #(
  parameter int    BIT_WIDTH = 8,
  parameter int    SIMD      = 1,
  parameter int    CHANNELS  = 1,
  parameter int    K         = 3,
  parameter int    IFM_W     = 256,
  parameter int    IFM_H     = 256,
  parameter int    STRIDE    = 1,
  parameter int    PAD       = 0,
  parameter string RAM_STYLE = "distributed"
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  input  logic                            in0_V_TVALID,
  output logic                            in0_V_TREADY,
  input  logic [BIT_WIDTH*SIMD-1:0]       in0_V_TDATA,
  output logic                            out_V_TVALID,
  input  logic                            out_V_TREADY,
  output logic [BIT_WIDTH*SIMD*K*K-1:0]   out_V_TDATA,
  output logic                            frame_done
);
  localparam int EW      = BIT_WIDTH * SIMD;
  localparam int CF      = CHANNELS / SIMD;
  localparam int P       = (PAD != 0) ? (K - 1) / 2 : 0;
  localparam int VW      = IFM_W + 2 * P;
  localparam int VH      = IFM_H + 2 * P;
  localparam int LEN     = VW * CF;
  localparam int SRL     = (K - 1) * CF;
  localparam int LAST_WR = K - 1 + ((VH - K) / STRIDE) * STRIDE;
  localparam int LAST_WC = K - 1 + ((VW - K) / STRIDE) * STRIDE;
  localparam int VR_W    = $clog2(VH);
  localparam int VC_W    = $clog2(VW);
  localparam int F_W     = (CF > 1) ? $clog2(CF) : 1;
  localparam int PTR_W   = $clog2(LEN);
  localparam int PH_W    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [VR_W-1:0]     vr_q, vr_d;
  logic [VC_W-1:0]     vc_q, vc_d;
  logic [F_W-1:0]      f_q, f_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PH_W-1:0]     rph_q, rph_d;
  logic [PH_W-1:0]     cph_q, cph_d;
  logic                out_valid_q, out_valid_d;
  logic [EW*K*K-1:0]   out_data_q, out_data_d;
  logic                last_q, last_d;
  logic [EW-1:0]       sr_q [K][SRL];
  logic [EW-1:0]       sr_d [K][SRL];

  logic                pad_pos;
  logic                stall;
  logic                adv;
  logic                win;
  logic                is_last;
  logic [EW-1:0]       elem;
  logic [EW-1:0]       col [K];
  logic [EW-1:0]       lb_rd [K-1];
  logic [EW-1:0]       lb_wr [K-1];
  logic [EW*K*K-1:0]   win_data;

  function automatic logic [PH_W-1:0] ph_next(input logic [PH_W-1:0] ph);
    return (int'(ph) == STRIDE - 1) ? '0 : ph + PH_W'(1);
  endfunction

  always_comb begin
    pad_pos = (int'(vr_q) < P) || (int'(vr_q) >= P + IFM_H) ||
              (int'(vc_q) < P) || (int'(vc_q) >= P + IFM_W);
    stall   = out_valid_q && !out_V_TREADY;
    adv     = !ap_rst && !stall && (pad_pos || in0_V_TVALID);
    elem    = pad_pos ? '0 : in0_V_TDATA;
    win     = (int'(vr_q) >= K - 1) && (int'(vc_q) >= K - 1) && (rph_q == '0) && (cph_q == '0);
    is_last = (int'(vr_q) == LAST_WR) && (int'(vc_q) == LAST_WC) && (int'(f_q) == CF - 1);
  end

  assign in0_V_TREADY = !ap_rst && !stall && !pad_pos;
  assign out_V_TVALID = out_valid_q;
  assign out_V_TDATA  = out_data_q;
  assign frame_done   = !ap_rst && out_valid_q && out_V_TREADY && last_q;

  // Each line buffer is indexed by (col, fold); buffer j feeds buffer j+1 so row age grows with j.
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    (* ram_style = RAM_STYLE *) logic [EW-1:0] lb_mem [LEN];
    if (j == 0) begin : g_first
      assign lb_wr[j] = elem;
    end else begin : g_rest
      assign lb_wr[j] = lb_rd[j-1];
    end
    assign lb_rd[j] = lb_mem[ptr_q];
    always_ff @(posedge ap_clk) begin
      if (adv) lb_mem[ptr_q] <= lb_wr[j];
    end
  end

  always_comb begin
    col[K-1] = elem;
    for (int j = 0; j < K - 1; j++) col[K-2-j] = lb_rd[j];
  end

  always_comb begin
    sr_d = sr_q;
    if (adv) begin
      for (int ky = 0; ky < K; ky++) begin
        sr_d[ky][0] = col[ky];
        for (int i = 1; i < SRL; i++) sr_d[ky][i] = sr_q[ky][i-1];
      end
    end
  end

  // Horizontal offset d (kx = K-1-d) of the same fold sits d*CF elements back in the row shift register.
  always_comb begin
    win_data = '0;
    for (int ky = 0; ky < K; ky++) begin
      win_data[(ky*K + K - 1)*EW +: EW] = col[ky];
      for (int d = 1; d < K; d++) win_data[(ky*K + K - 1 - d)*EW +: EW] = sr_q[ky][d*CF - 1];
    end
  end

  always_comb begin
    vr_d  = vr_q;
    vc_d  = vc_q;
    f_d   = f_q;
    ptr_d = ptr_q;
    rph_d = rph_q;
    cph_d = cph_q;
    if (adv) begin
      ptr_d = (ptr_q == PTR_W'(LEN - 1)) ? '0 : ptr_q + PTR_W'(1);
      if (f_q == F_W'(CF - 1)) begin
        f_d = '0;
        if (vc_q == VC_W'(VW - 1)) begin
          vc_d  = '0;
          cph_d = '0;
          if (vr_q == VR_W'(VH - 1)) begin
            vr_d  = '0;
            rph_d = '0;
          end else begin
            vr_d  = vr_q + VR_W'(1);
            rph_d = (int'(vr_q) >= K - 1) ? ph_next(rph_q) : '0;
          end
        end else begin
          vc_d  = vc_q + VC_W'(1);
          cph_d = (int'(vc_q) >= K - 1) ? ph_next(cph_q) : '0;
        end
      end else begin
        f_d = f_q + F_W'(1);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    last_d      = last_q;
    if (adv && win) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      last_d      = is_last;
    end else if (out_valid_q && out_V_TREADY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vr_q        <= '0;
      vc_q        <= '0;
      f_q         <= '0;
      ptr_q       <= '0;
      rph_q       <= '0;
      cph_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      last_q      <= 1'b0;
    end else begin
      vr_q        <= vr_d;
      vc_q        <= vc_d;
      f_q         <= f_d;
      ptr_q       <= ptr_d;
      rph_q       <= rph_d;
      cph_q       <= cph_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      last_q      <= last_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    sr_q <= sr_d;
  end

endmodule

// File: tb/tb_swg_window_gen.sv
// Directed bench for swg_window_gen: four 4x4, K=3 instances (plain, padded, padded stride 2, two folds).
// Every input beat carries its own beat index, so pixel value = (r*4+c)*CF+f.
module tb_swg_window_gen;
  localparam int N = 4;

  localparam logic [71:0] W_BASIC [4] = '{
    72'h0a_09_08_06_05_04_02_01_00,
    72'h0b_0a_09_07_06_05_03_02_01,
    72'h0e_0d_0c_0a_09_08_06_05_04,
    72'h0f_0e_0d_0b_0a_09_07_06_05
  };
  localparam logic [71:0] W_PAD_FIRST  = 72'h05_04_00_01_00_00_00_00_00;
  localparam logic [71:0] W_PAD_SECOND = 72'h06_05_04_02_01_00_00_00_00;
  localparam logic [71:0] W_PAD_LAST   = 72'h00_00_00_00_0f_0e_00_0b_0a;
  localparam logic [71:0] W_STR_SECOND = 72'h07_06_05_03_02_01_00_00_00;
  localparam logic [71:0] W_STR_THIRD  = 72'h0d_0c_00_09_08_00_05_04_00;
  localparam logic [71:0] W_FOLD0      = 72'h14_12_10_0c_0a_08_04_02_00;
  localparam logic [71:0] W_FOLD1      = 72'h15_13_11_0d_0b_09_05_03_01;
  localparam logic [71:0] W_FOLD7      = 72'h1f_1d_1b_17_15_13_0f_0d_0b;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] in_valid, in_ready, out_valid, out_ready, done;
  logic [7:0]   in_data  [N];
  logic [71:0]  out_data [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    swg_window_gen #(
      .BIT_WIDTH(8), .SIMD(1), .CHANNELS((g == 3) ? 2 : 1), .K(3),
      .IFM_W(4), .IFM_H(4), .STRIDE((g == 2) ? 2 : 1), .PAD((g == 1 || g == 2) ? 1 : 0),
      .RAM_STYLE("distributed")
    ) u_dut (
      .ap_clk       (clk),
      .ap_rst       (rst),
      .in0_V_TVALID (in_valid[g]),
      .in0_V_TREADY (in_ready[g]),
      .in0_V_TDATA  (in_data[g]),
      .out_V_TVALID (out_valid[g]),
      .out_V_TREADY (out_ready[g]),
      .out_V_TDATA  (out_data[g]),
      .frame_done   (done[g])
    );
  end

  int          beat_cnt [N];
  int          beat_lim [N];
  int          win_cnt  [N];
  int          done_cnt [N];
  int          done_at  [N];
  int          done_cyc [N];
  int          rdy_cyc  [N];
  logic [71:0] win_mem  [N][32];
  logic [7:0]  data_ofs;
  int          cyc;
  int          bp_left;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Holds reset for one clock edge, clears the scoreboard and checks the post-reset outputs.
  task automatic resetDut(input int lim, input logic [7:0] ofs);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 8'h00;
      out_ready[i] = 1'b1;
      beat_cnt[i]  = 0;
      beat_lim[i]  = (i == 3) ? 2 * lim : lim;
      win_cnt[i]   = 0;
      done_cnt[i]  = 0;
      done_at[i]   = -1;
      done_cyc[i]  = -1;
      rdy_cyc[i]   = 0;
    end
    data_ofs = ofs;
    cyc      = 0;
    bp_left  = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("rst_valid%0d", i), 72'(out_valid[i]), 72'd0);
      checkOutput($sformatf("rst_data%0d", i), out_data[i], 72'd0);
      checkOutput($sformatf("rst_in_ready%0d", i), 72'(in_ready[i]), 72'd0);
      checkOutput($sformatf("rst_done%0d", i), 72'(done[i]), 72'd0);
    end
    rst = 1'b0;
  endtask

  // One iteration per clock: drive just after the edge, sample at the falling edge.
  task automatic applyStimulus(input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i]  = (beat_cnt[i] < beat_lim[i]);
        in_data[i]   = 8'(beat_cnt[i]) + data_ofs;
        out_ready[i] = 1'b1;
      end
      if (bp_left > 0 && out_valid[0]) begin
        out_ready[0] = 1'b0;
        bp_left--;
      end
      @(negedge clk);
      if (!out_ready[0]) begin
        checkOutput("bp_data", out_data[0], W_BASIC[0]);
        checkOutput("bp_valid", 72'(out_valid[0]), 72'd1);
        checkOutput("bp_in_ready", 72'(in_ready[0]), 72'd0);
      end
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && in_ready[i]) beat_cnt[i]++;
        if (out_valid[i] && out_ready[i]) begin
          if (win_cnt[i] < 32) win_mem[i][win_cnt[i]] = out_data[i];
          win_cnt[i]++;
        end
        if (done[i]) begin
          done_cnt[i]++;
          done_at[i]  = win_cnt[i];
          done_cyc[i] = cyc;
        end
        if (in_ready[i] && cyc < 36) rdy_cyc[i]++;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkBasic(input string tag);
    checkOutput({tag, "_count"}, 72'(win_cnt[0]), 72'd4);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("%s_win%0d", tag, k), win_mem[0][k], W_BASIC[k]);
    checkOutput({tag, "_done_cnt"}, 72'(done_cnt[0]), 72'd1);
    checkOutput({tag, "_done_at"}, 72'(done_at[0]), 72'd4);
  endtask

  initial begin
    rst = 1'b1;
    resetDut(16, 8'd0);
    applyStimulus(60);

    checkBasic("basic");
    checkOutput("basic_done_cyc", 72'(done_cyc[0]), 72'd16);

    checkOutput("pad_count", 72'(win_cnt[1]), 72'd16);
    checkOutput("pad_first", win_mem[1][0], W_PAD_FIRST);
    checkOutput("pad_second", win_mem[1][1], W_PAD_SECOND);
    checkOutput("pad_last", win_mem[1][15], W_PAD_LAST);
    checkOutput("pad_done_cnt", 72'(done_cnt[1]), 72'd1);
    checkOutput("pad_done_at", 72'(done_at[1]), 72'd16);
    checkOutput("pad_done_cyc", 72'(done_cyc[1]), 72'd36);
    checkOutput("pad_ready_cycles", 72'(rdy_cyc[1]), 72'd16);

    checkOutput("stride_count", 72'(win_cnt[2]), 72'd4);
    checkOutput("stride_win0", win_mem[2][0], W_PAD_FIRST);
    checkOutput("stride_win1", win_mem[2][1], W_STR_SECOND);
    checkOutput("stride_win2", win_mem[2][2], W_STR_THIRD);
    checkOutput("stride_win3", win_mem[2][3], W_BASIC[3]);
    checkOutput("stride_done_at", 72'(done_at[2]), 72'd4);

    checkOutput("fold_count", 72'(win_cnt[3]), 72'd8);
    checkOutput("fold_win0", win_mem[3][0], W_FOLD0);
    checkOutput("fold_win1", win_mem[3][1], W_FOLD1);
    checkOutput("fold_win7", win_mem[3][7], W_FOLD7);
    checkOutput("fold_done_at", 72'(done_at[3]), 72'd8);
    checkOutput("fold_done_cyc", 72'(done_cyc[3]), 72'd32);

    resetDut(16, 8'd0);
    bp_left = 5;
    applyStimulus(50);
    checkOutput("bp_all_stalls_seen", 72'(bp_left), 72'd0);
    checkBasic("bp");

    resetDut(7, 8'd100);
    applyStimulus(12);
    checkOutput("prerst_beats", 72'(beat_cnt[0]), 72'd7);
    checkOutput("prerst_count", 72'(win_cnt[0]), 72'd0);
    resetDut(16, 8'd0);
    applyStimulus(40);
    checkBasic("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
